m2vcolbuf: RTL and testbench
============================

Name: m2vcolbuf

Overview:
- Sits between the inverse-scan/dequantiser stage and the IDCT row/column engine.
- Pulls the 64 dequantised coefficients of each block through the coef_next handshake and converts them from sign-magnitude to 12-bit two's complement.
- Assembles the coefficients into 8-coefficient column vectors and presents one column at a time to the IDCT, under valid/ready flow control.
- Attaches per-column non-zero masks and a block-all-zero flag so the IDCT can skip work.

Parameters:
- CW, 12, coefficient width (magnitude and output); fixed at 12 for this codec, exposed only for the bench.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- softreset  in  1  synchronous reset, same effect as reset_n
- blk_ready  in  1  1-cycle pulse: the dequantiser has one more complete block (64 coefs) available
- coef_next  out  1  request for the next coefficient
- coef_sign  in  1  coefficient sign, 1 = negative
- coef_data  in  12  coefficient magnitude
- col_valid  out  1  col_* outputs hold a valid column
- col_ready  in  1  IDCT accepts the column; transfer occurs when col_valid & col_ready
- col_data  out  96  rows 0..7 of the column; row r at bits [12r+11:12r], two's complement
- col_index  out  3  column number 0..7 within the block
- col_nz  out  8  bit r = 1 when row r of the column is non-zero
- col_last  out  1  marks column 7 of the block
- blk_zero  out  1  valid with col_last: all 64 coefficients of the block were zero
- busy  out  1  pending block count non-zero, or column data held internally
- err_ovf  out  1  sticky: blk_ready arrived while 2 blocks were already pending

Behaviour:

Reset:
- reset_n low, or softreset high at a clock edge, forces state IDLE.
- All counters are cleared, both column registers are emptied, and in-flight coefficients are discarded.
- All outputs become 0; err_ovf is cleared.

Coefficient input timing:
- Coefficient k of a block is sampled in the cycle after the k-th coef_next pulse.
- Coefficients arrive in order k = 0..63: column c = k[5:3], row r = k[2:0].

Conversion:
- val = coef_sign ? (~coef_data + 1) : coef_data, truncated to 12 bits.
- sign=1 with magnitude 0x800 gives 0x800 (-2048).
- sign=1 with magnitude 0 gives 0.
- A row is non-zero when val != 0.

Pending counter (0..2):
- blk_ready increments it.
- Issuing the 64th coef_next of a block decrements it.
- Both in the same cycle: count unchanged.
- blk_ready at count 2 (with no decrement in that cycle) is ignored and sets err_ovf.

State machine:
- IDLE: go to BURST when pending > 0 and the assembly register is empty.
- BURST: coef_next high for exactly 8 consecutive cycles (burst counter 0..7), then go to WAIT.
- WAIT: last datum captured, then the assembly register is full. Move it to the output register when the output register is empty or is being popped in that same cycle. After the move, go to BURST if coefficients of the current block remain or pending > 0; otherwise go to IDLE.
- If the output register stays occupied, the block holds in WAIT with coef_next low.

Output register:
- Loads col_data, col_index, col_nz and col_last (col_index == 7).
- blk_zero = col_last & (no non-zero row in any of the 8 columns); the block zero accumulator resets after column 7 is loaded.
- col_* are stable while col_valid & ~col_ready.
- col_valid drops the cycle after a pop unless a new column loads in that same cycle.

Latency:
- blk_ready in cycle 0 with the block idle: coef_next in cycles 1–8, data in cycles 2–9, col_valid = 1 with col_index = 0 in cycle 10.
- Next burst runs in cycles 10–17.
- With col_ready held high, one column every 9 cycles and one block every 72 cycles.
- Back-to-back blocks: column 0 of block n+1 follows column 7 of block n with no gap.

Test Plan:
1. Single block, coefficient k = k+1 (positive), col_ready = 1 -> coef_next in cycles 1–8; col 0 in cycle 10 with rows 1..8 and col_nz = 0xFF; cols 1..7 at 9-cycle intervals; col_last only on col 7; blk_zero = 0.
2. All-zero block, including sign=1 with magnitude 0 -> every col_nz = 0x00, every col_data = 0, blk_zero = 1 on col 7.
3. Sign-magnitude edges: (1,0x800) -> 0x800; (1,0x001) -> 0xFFF; (0,0x7FF) -> 0x7FF; col_nz bits set exactly for those rows.
4. col_ready held low from cycle 10 for 30 cycles -> col 0 stays stable; col 1 assembles, then coef_next stays low in WAIT; after release, col 1 appears the cycle after the pop, and the next burst starts the same cycle.
5. Three blk_ready pulses with no gap between them -> err_ovf = 1, only 2 blocks emitted (16 columns, 128 coef_next); busy drops after the last pop.
6. softreset asserted mid-burst (coefficient 13) -> next cycle coef_next = 0, col_valid = 0, busy = 0; a fresh blk_ready then produces col_index 0 with correct data.

Source files
------------

// File: rtl/m2vcolbuf.sv
// m2vcolbuf: column buffer between the dequantiser and the IDCT engine.
// Pulls 64 sign-magnitude coefficients per block in 8-coefficient bursts,
// converts them to two's complement and hands 8-row column vectors to the
// IDCT under valid/ready, with per-column non-zero masks and a block-zero flag.
//
// Ports:
//   clk, reset_n (async, active-low), softreset (sync, same effect)
//   blk_ready            : pulse, one more full block is available upstream
//   coef_next            : coefficient request; data follows one cycle later
//   coef_sign, coef_data : sign-magnitude coefficient (sign 1 = negative)
//   col_valid/col_ready  : column handshake towards the IDCT
//   col_data             : rows 0..7, row r at [CW*r +: CW]
//   col_index, col_nz, col_last, blk_zero : column side information
//   busy                 : blocks pending or column data held internally
//   err_ovf              : sticky, blk_ready seen with two blocks pending
//
// state | meaning
// IDLE  | nothing to fetch
// BURST | coef_next high for 8 cycles (one column)
// WAIT  | column assembling/full, waiting for the output register

module m2vcolbuf #(
  parameter int CW = 12
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            softreset,
  input  logic            blk_ready,
  output logic            coef_next,
  input  logic            coef_sign,
  input  logic [CW-1:0]   coef_data,
  output logic            col_valid,
  input  logic            col_ready,
  output logic [8*CW-1:0] col_data,
  output logic [2:0]      col_index,
  output logic [7:0]      col_nz,
  output logic            col_last,
  output logic            blk_zero,
  output logic            busy,
  output logic            err_ovf
);

  typedef enum logic [1:0] {IDLE, BURST, WAIT} state_t;

  state_t             state_q;
  logic               coef_next_q, vld_q, asm_full_q, col_valid_q;
  logic               col_last_q, blk_zero_q, zacc_q, err_q;
  logic [2:0]         bcnt_q, icol_q, wrow_q, ocol_q, col_index_q;
  logic [1:0]         pend_q;
  logic [7:0][CW-1:0] asm_q, col_data_q, vec_now;
  logic [7:0]         asm_nz_q, col_nz_q, nz_now;
  logic [CW-1:0]      conv;
  logic               conv_nz, last_in, full_now, move, issue_last, more;

  assign conv    = coef_sign ? (~coef_data + CW'(1)) : coef_data;
  assign conv_nz = |conv;

  // The 8th datum of a column is forwarded straight into the output register
  // so the column is visible the cycle after it arrives.
  assign last_in    = vld_q && (wrow_q == 3'd7);
  assign full_now   = asm_full_q || last_in;
  assign move       = (state_q == WAIT) && full_now && (!col_valid_q || col_ready);
  // The current block stays counted in pend_q until its 64th request goes out,
  // so pend_q != 0 also covers "columns of this block remain".
  assign issue_last = coef_next_q && (bcnt_q == 3'd7) && (icol_q == 3'd7);
  assign more       = (pend_q != 2'd0) || blk_ready;

  always_comb begin
    vec_now = asm_q;
    nz_now  = asm_nz_q;
    if (vld_q) begin
      vec_now[7] = conv;
      nz_now[7]  = conv_nz;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      coef_next_q <= 1'b0;
      vld_q       <= 1'b0;
      bcnt_q      <= 3'd0;
      icol_q      <= 3'd0;
      wrow_q      <= 3'd0;
      ocol_q      <= 3'd0;
      pend_q      <= 2'd0;
      asm_q       <= '0;
      asm_nz_q    <= 8'h00;
      asm_full_q  <= 1'b0;
      col_valid_q <= 1'b0;
      col_data_q  <= '0;
      col_index_q <= 3'd0;
      col_nz_q    <= 8'h00;
      col_last_q  <= 1'b0;
      blk_zero_q  <= 1'b0;
      zacc_q      <= 1'b0;
      err_q       <= 1'b0;
    end else if (softreset) begin
      state_q     <= IDLE;
      coef_next_q <= 1'b0;
      vld_q       <= 1'b0;
      bcnt_q      <= 3'd0;
      icol_q      <= 3'd0;
      wrow_q      <= 3'd0;
      ocol_q      <= 3'd0;
      pend_q      <= 2'd0;
      asm_q       <= '0;
      asm_nz_q    <= 8'h00;
      asm_full_q  <= 1'b0;
      col_valid_q <= 1'b0;
      col_data_q  <= '0;
      col_index_q <= 3'd0;
      col_nz_q    <= 8'h00;
      col_last_q  <= 1'b0;
      blk_zero_q  <= 1'b0;
      zacc_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // pending block count
      if (blk_ready && !issue_last) begin
        if (pend_q == 2'd2) err_q <= 1'b1;
        else                pend_q <= pend_q + 2'd1;
      end else if (issue_last && !blk_ready) begin
        pend_q <= pend_q - 2'd1;
      end

      // coefficient capture, one cycle behind the request
      vld_q <= coef_next_q;
      if (vld_q) begin
        asm_q[wrow_q]    <= conv;
        asm_nz_q[wrow_q] <= conv_nz;
        wrow_q           <= wrow_q + 3'd1;
      end
      if (move)         asm_full_q <= 1'b0;
      else if (last_in) asm_full_q <= 1'b1;

      // output register
      if (move) begin
        col_valid_q <= 1'b1;
        col_data_q  <= vec_now;
        col_nz_q    <= nz_now;
        col_index_q <= ocol_q;
        col_last_q  <= (ocol_q == 3'd7);
        blk_zero_q  <= (ocol_q == 3'd7) && !(zacc_q || (|nz_now));
        zacc_q      <= (ocol_q == 3'd7) ? 1'b0 : (zacc_q || (|nz_now));
        ocol_q      <= ocol_q + 3'd1;
      end else if (col_valid_q && col_ready) begin
        col_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (more && !asm_full_q) begin
            state_q     <= BURST;
            coef_next_q <= 1'b1;
          end
        end
        BURST: begin
          bcnt_q <= bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) begin
            state_q     <= WAIT;
            coef_next_q <= 1'b0;
            icol_q      <= icol_q + 3'd1;
          end
        end
        WAIT: begin
          if (move) begin
            if (more) begin
              state_q     <= BURST;
              coef_next_q <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign coef_next = coef_next_q;
  assign col_valid = col_valid_q;
  assign col_data  = col_data_q;
  assign col_index = col_index_q;
  assign col_nz    = col_nz_q;
  assign col_last  = col_last_q;
  assign blk_zero  = blk_zero_q;
  assign err_ovf   = err_q;
  assign busy      = (pend_q != 2'd0) || col_valid_q || asm_full_q || vld_q ||
                     (wrow_q != 3'd0);

endmodule

// File: tb/tb_m2vcolbuf.sv
module tb_m2vcolbuf;
  logic        clk = 1'b0;
  logic        reset_n, softreset, blk_ready, coef_next, coef_sign;
  logic [11:0] coef_data;
  logic        col_valid, col_ready;
  logic [95:0] col_data;
  logic [2:0]  col_index;
  logic [7:0]  col_nz;
  logic        col_last, blk_zero, busy, err_ovf;

  int total = 0, bad = 0;
  int cyc, kidx, npop, ncoef;
  int popcyc[24];
  int cncyc[16];
  logic        tsign[192];
  logic [11:0] tmag[192];
  logic        pn, last_pop_busy, last_bz;
  logic [95:0] first_data, hold;
  logic [7:0]  first_nz;
  int          stable_cnt, cw;

  m2vcolbuf #(.CW(12)) dut (
    .clk(clk), .reset_n(reset_n), .softreset(softreset), .blk_ready(blk_ready),
    .coef_next(coef_next), .coef_sign(coef_sign), .coef_data(coef_data),
    .col_valid(col_valid), .col_ready(col_ready), .col_data(col_data),
    .col_index(col_index), .col_nz(col_nz), .col_last(col_last),
    .blk_zero(blk_zero), .busy(busy), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [11:0] exp_conv(input logic s, input logic [11:0] m);
    int v;
    v = s ? (0 - int'(m)) : int'(m);
    return v[11:0];
  endfunction

  task automatic check_pop();
    int b, c, base;
    logic [95:0] ed;
    logic [7:0]  en;
    logic [11:0] v;
    logic        bz;
    if (npop < 24) begin
      b = npop / 8;
      c = npop % 8;
      base = b * 64;
      for (int r = 0; r < 8; r++) begin
        v = exp_conv(tsign[base + c*8 + r], tmag[base + c*8 + r]);
        ed[12*r +: 12] = v;
        en[r] = (v != 12'h000);
      end
      bz = 1'b1;
      for (int k = 0; k < 64; k++)
        if (exp_conv(tsign[base + k], tmag[base + k]) != 12'h000) bz = 1'b0;
      chk("col_index", 96'(col_index), 96'(c));
      chk("col_data", col_data, ed);
      chk("col_nz", 96'(col_nz), 96'(en));
      chk("col_last", 96'(col_last), 96'(c == 7));
      chk("blk_zero", 96'(blk_zero), 96'((c == 7) && bz));
      popcyc[npop] = cyc;
      if (npop == 0) begin
        first_data = col_data;
        first_nz   = col_nz;
      end
      last_pop_busy = busy;
      last_bz       = blk_zero;
    end
    npop++;
  endtask

  // Samples the current cycle, advances one clock and supplies the
  // coefficient requested in the cycle just finished.
  task automatic step();
    if (coef_next) begin
      if (ncoef < 16) cncyc[ncoef] = cyc;
      ncoef++;
    end
    if (col_valid && col_ready) check_pop();
    pn = coef_next;
    @(posedge clk);
    #1;
    cyc++;
    blk_ready = 1'b0;
    if (pn && kidx < 192) begin
      coef_sign = tsign[kidx];
      coef_data = tmag[kidx];
      kidx++;
    end else begin
      coef_sign = 1'b0;
      coef_data = 12'h000;
    end
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    softreset = 1'b0;
    blk_ready = 1'b0;
    col_ready = 1'b0;
    coef_sign = 1'b0;
    coef_data = 12'h000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    cyc = 0; kidx = 0; npop = 0; ncoef = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    cyc = 0;
    do_reset();
    chk("rst coef_next", 96'(coef_next), 96'(0));
    chk("rst col_valid", 96'(col_valid), 96'(0));
    chk("rst busy", 96'(busy), 96'(0));
    chk("rst err_ovf", 96'(err_ovf), 96'(0));
    chk("rst col_data", col_data, 96'(0));

    // 1: single positive block, coefficient k = k+1
    for (int k = 0; k < 192; k++) begin tsign[k] = 1'b0; tmag[k] = 12'(k + 1); end
    col_ready = 1'b1;
    blk_ready = 1'b1;
    repeat (85) step();
    chk("t1 npop", 96'(npop), 96'(8));
    chk("t1 first coef_next", 96'(cncyc[0]), 96'(1));
    chk("t1 8th coef_next", 96'(cncyc[7]), 96'(8));
    chk("t1 9th coef_next", 96'(cncyc[8]), 96'(10));
    chk("t1 col0 cycle", 96'(popcyc[0]), 96'(10));
    chk("t1 col1 cycle", 96'(popcyc[1]), 96'(19));
    chk("t1 col7 cycle", 96'(popcyc[7]), 96'(73));
    chk("t1 col0 data", first_data, 96'h008_007_006_005_004_003_002_001);
    chk("t1 col0 nz", 96'(first_nz), 96'(8'hFF));
    chk("t1 blk_zero", 96'(last_bz), 96'(0));

    // 2: all-zero block with negative zeros
    do_reset();
    for (int k = 0; k < 192; k++) begin tsign[k] = k[0]; tmag[k] = 12'h000; end
    col_ready = 1'b1;
    blk_ready = 1'b1;
    repeat (85) step();
    chk("t2 npop", 96'(npop), 96'(8));
    chk("t2 col0 nz", 96'(first_nz), 96'(0));
    chk("t2 blk_zero", 96'(last_bz), 96'(1));

    // 3: sign-magnitude edges
    do_reset();
    for (int k = 0; k < 192; k++) begin tsign[k] = 1'b0; tmag[k] = 12'h000; end
    tsign[0] = 1'b1; tmag[0] = 12'h800;
    tsign[1] = 1'b1; tmag[1] = 12'h001;
    tsign[2] = 1'b0; tmag[2] = 12'h7FF;
    tsign[5] = 1'b1; tmag[5] = 12'h000;
    tsign[27] = 1'b1; tmag[27] = 12'h800;
    col_ready = 1'b1;
    blk_ready = 1'b1;
    repeat (85) step();
    chk("t3 npop", 96'(npop), 96'(8));
    chk("t3 col0 data", first_data, 96'h000_000_000_000_000_7FF_FFF_800);
    chk("t3 col0 nz", 96'(first_nz), 96'(8'h07));

    // 4: output back-pressure
    do_reset();
    for (int k = 0; k < 192; k++) begin tsign[k] = k[1]; tmag[k] = 12'(k + 1); end
    col_ready = 1'b1;
    blk_ready = 1'b1;
    while (cyc < 10) step();
    col_ready = 1'b0;
    chk("t4 col0 valid", 96'(col_valid), 96'(1));
    hold = col_data;
    stable_cnt = 0;
    cw = 0;
    for (int i = 0; i < 30; i++) begin
      if (col_valid && col_index == 3'd0 && col_data === hold) stable_cnt++;
      if (cyc >= 18 && coef_next) cw++;
      step();
    end
    chk("t4 stable", 96'(stable_cnt), 96'(30));
    chk("t4 coef_next in wait", 96'(cw), 96'(0));
    col_ready = 1'b1;
    step();
    chk("t4 pop cycle", 96'(popcyc[0]), 96'(40));
    chk("t4 col1 valid", 96'(col_valid), 96'(1));
    chk("t4 col1 index", 96'(col_index), 96'(1));
    chk("t4 burst restart", 96'(coef_next), 96'(1));
    repeat (90) step();
    chk("t4 npop", 96'(npop), 96'(8));

    // 5: three back-to-back blk_ready pulses
    do_reset();
    for (int k = 0; k < 192; k++) begin tsign[k] = k[0]; tmag[k] = 12'((k*37 + 5) % 4096); end
    col_ready = 1'b1;
    blk_ready = 1'b1; step();
    blk_ready = 1'b1; step();
    blk_ready = 1'b1; step();
    repeat (170) begin
      step();
      if (npop == 16 && cyc == popcyc[15] + 1) chk("t5 busy after pop", 96'(busy), 96'(0));
    end
    chk("t5 err_ovf", 96'(err_ovf), 96'(1));
    chk("t5 npop", 96'(npop), 96'(16));
    chk("t5 ncoef", 96'(ncoef), 96'(128));
    chk("t5 last pop cycle", 96'(popcyc[15]), 96'(145));
    chk("t5 block gap", 96'(popcyc[8] - popcyc[7]), 96'(9));
    chk("t5 busy at pop", 96'(last_pop_busy), 96'(1));
    chk("t5 busy end", 96'(busy), 96'(0));
    do_reset();
    chk("t5 err cleared", 96'(err_ovf), 96'(0));

    // 6: softreset mid-burst
    for (int k = 0; k < 192; k++) begin tsign[k] = 1'b0; tmag[k] = 12'(k + 1); end
    col_ready = 1'b1;
    blk_ready = 1'b1;
    while (cyc < 15) step();
    chk("t6 coef13 request", 96'(coef_next), 96'(1));
    softreset = 1'b1;
    step();
    softreset = 1'b0;
    chk("t6 coef_next", 96'(coef_next), 96'(0));
    chk("t6 col_valid", 96'(col_valid), 96'(0));
    chk("t6 busy", 96'(busy), 96'(0));
    for (int k = 0; k < 192; k++) begin tsign[k] = 1'b1; tmag[k] = 12'(k + 3); end
    repeat (3) step();
    kidx = 0; npop = 0; ncoef = 0; cyc = 0;
    blk_ready = 1'b1;
    repeat (20) step();
    chk("t6 npop", 96'(npop), 96'(2));
    chk("t6 col0 cycle", 96'(popcyc[0]), 96'(10));
    chk("t6 col0 data", first_data, 96'hFF6_FF7_FF8_FF9_FFA_FFB_FFC_FFD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
